// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer: sequencer states and
// channel geometry of the 4-to-1 mux it drives.
package mux_scan_sequencer_pkg;

  // Number of mux inputs and the width of the select bus that addresses them.
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Width of the dwell counter and of the transfer counter.
  localparam int CNT_W  = 8;

  // IDLE:   not scanning, waiting for start.
  // SETTLE: select driven, waiting out the settle window before capture.
  // HOLD:   sample captured and offered downstream, waiting for the handshake.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_sequencer_rr_next_channel.sv
// Round-robin channel picker: returns the first enabled channel strictly
// after cur, wrapping past the top channel. With cur = NUM_CH-1 this yields
// the lowest enabled channel. If only cur is enabled, cur is returned.
module rr_next_channel
  import mux_scan_sequencer_pkg::*;
(
  input  logic [SEL_W-1:0]  cur,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  nxt,
  output logic              any
);

  // Scan candidates from furthest to nearest so the nearest enabled one wins.
  // Offset NUM_CH wraps back onto cur itself, covering the single-channel case.
  always_comb begin
    nxt = cur;
    any = |mask;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (mask[SEL_W'(int'(cur) + i)]) begin
        nxt = SEL_W'(int'(cur) + i);
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Mux scan sequencer: walks the enabled channels of a 4-to-1 mux in
// round-robin order, waits a settle window on each select, captures the mux
// output and hands it downstream over valid/ready, tagged with its channel.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DWELL = 4   // settle cycles before capture, 1..255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [SEL_W-1:0]  select,
  input  logic [WIDTH-1:0]  mux_out,
  output logic [WIDTH-1:0]  out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  scan_cnt
);

  // Dwell counter value on the capture cycle.
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t             state_q,     state_d;
  logic [SEL_W-1:0]   select_q,    select_d;
  logic [WIDTH-1:0]   out_data_q,  out_data_d;
  logic [SEL_W-1:0]   out_ch_q,    out_ch_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q,      busy_d;
  logic [CNT_W-1:0]   scan_cnt_q,  scan_cnt_d;
  logic [CNT_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic               stop_pend_q, stop_pend_d;

  logic [SEL_W-1:0]   first_ch;
  logic               first_any;
  logic [SEL_W-1:0]   next_ch;
  logic               next_any;
  logic               handshake;

  // Lowest enabled channel, used when a scan starts.
  rr_next_channel u_rr_first (
    .cur  (SEL_W'(NUM_CH - 1)),
    .mask (ch_mask),
    .nxt  (first_ch),
    .any  (first_any)
  );

  // Channel following the current select, used on each advance.
  rr_next_channel u_rr_next (
    .cur  (select_q),
    .mask (ch_mask),
    .nxt  (next_ch),
    .any  (next_any)
  );

  assign handshake = out_valid_q & out_ready;

  // Next-state and datapath decisions; every register holds unless told otherwise.
  always_comb begin
    state_d     = state_q;
    select_d    = select_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    scan_cnt_d  = scan_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    stop_pend_d = stop_pend_q;

    case (state_q)
      ST_IDLE: begin
        // start with no enabled channel is ignored, and so is a lone stop.
        if (start && first_any) begin
          state_d     = ST_SETTLE;
          select_d    = first_ch;
          dwell_cnt_d = '0;
          stop_pend_d = stop;
        end
      end

      ST_SETTLE: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        dwell_cnt_d = dwell_cnt_q + 1'b1;
        if (dwell_cnt_q == DWELL_LAST) begin
          out_data_d  = mux_out;
          out_ch_d    = select_q;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (handshake) begin
          out_valid_d = 1'b0;
          scan_cnt_d  = scan_cnt_q + 1'b1;
          // A stop arriving on the handshake cycle itself also ends the scan.
          if (stop_pend_q || stop || !next_any) begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
          end else begin
            state_d     = ST_SETTLE;
            select_d    = next_ch;
            dwell_cnt_d = '0;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        stop_pend_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops everything, including a sample on offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      select_q    <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      scan_cnt_q  <= '0;
      dwell_cnt_q <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      select_q    <= select_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      scan_cnt_q  <= scan_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign select    = select_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign scan_cnt  = scan_cnt_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a directed vector table, hand-written corner
// sequences, and a randomized run, all cross-checked every cycle against a
// transaction-level reference model.
module tb_mux_scan_sequencer;

  localparam int WIDTH = 5;
  localparam int DWELL = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [3:0]       ch_mask = 4'h0;
  logic             out_ready = 1'b0;
  logic [1:0]       select;
  logic [WIDTH-1:0] mux_out;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_ch;
  logic             out_valid;
  logic             busy;
  logic [7:0]       scan_cnt;

  // The mux itself: four input values, selected by the DUT.
  logic [WIDTH-1:0] chan_val [4];
  assign mux_out = chan_val[select];

  int vectors = 0;
  int miscompares = 0;

  mux_scan_sequencer #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .ch_mask   (ch_mask),
    .select    (select),
    .mux_out   (mux_out),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .scan_cnt  (scan_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit               m_scanning;
  bit               m_waiting;
  bit               m_stop;
  bit               m_valid;
  int               m_left;
  logic [1:0]       m_sel;
  logic [1:0]       m_ch;
  logic [WIDTH-1:0] m_data;
  int               m_cnt;

  function automatic logic [1:0] first_after(input int cur, input logic [3:0] mask);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (cur + k) % 4;
      if (mask[c]) return 2'(c);
    end
    return 2'(cur);
  endfunction

  task automatic model_reset();
    m_scanning = 0; m_waiting = 0; m_stop = 0; m_valid = 0;
    m_left = 0; m_sel = 0; m_ch = 0; m_data = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    if (!m_scanning) begin
      if (start && ch_mask != 4'h0) begin
        m_scanning = 1;
        m_waiting  = 0;
        m_sel      = first_after(3, ch_mask);
        m_left     = DWELL;
        m_stop     = stop;
      end
    end else if (!m_waiting) begin
      if (stop) m_stop = 1;
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_data    = chan_val[m_sel];
        m_ch      = m_sel;
        m_valid   = 1;
        m_waiting = 1;
      end
    end else begin
      if (stop) m_stop = 1;
      if (out_ready) begin
        m_valid = 0;
        m_cnt   = (m_cnt + 1) % 256;
        if (m_stop || ch_mask == 4'h0) begin
          m_scanning = 0;
          m_waiting  = 0;
          m_stop     = 0;
        end else begin
          m_sel     = first_after(int'(m_sel), ch_mask);
          m_waiting = 0;
          m_left    = DWELL;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    vectors++;
    if (select !== m_sel || out_data !== m_data || out_ch !== m_ch ||
        out_valid !== m_valid || busy !== m_scanning || scan_cnt !== 8'(m_cnt)) begin
      miscompares++;
      $display("FAIL model[%s] t=%0t got sel=%0d data=%0d ch=%0d valid=%0d busy=%0d cnt=%0d expected sel=%0d data=%0d ch=%0d valid=%0d busy=%0d cnt=%0d",
               tag, $time, select, out_data, out_ch, out_valid, busy, scan_cnt,
               m_sel, m_data, m_ch, m_valid, m_scanning, m_cnt);
    end
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One clock: model follows the edge, DUT is compared on the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic drive(input bit s, input bit p, input logic [3:0] m, input bit r);
    start = s; stop = p; ch_mask = m; out_ready = r;
  endtask

  // Pulse reset for one cycle; outputs must clear before any clock edge.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 4'h0, 0);
    #1;
    model_reset();
    check_model("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid) begin ok = 1; break; end
      cycle(tag);
    end
    chk({tag, "_valid_seen"}, int'(ok), 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         start;
    logic [1:0] exp_sel;
    bit         exp_valid;
    logic [1:0] exp_ch;
    int         exp_data;
    bit         exp_busy;
    int         exp_cnt;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(bit s, int sel, bit v, int ch, int d, bit b, int c);
    vec_t r;
    r.start = s; r.exp_sel = 2'(sel); r.exp_valid = v; r.exp_ch = 2'(ch);
    r.exp_data = d; r.exp_busy = b; r.exp_cnt = c;
    return r;
  endfunction

  initial begin
    logic [1:0] got_ch [$];
    logic [1:0] exp_seq [4];
    logic [WIDTH-1:0] snap_data;
    logic [1:0]       snap_ch;
    logic [1:0]       snap_sel;
    int               snap_cnt;
    int               hs;

    // mask=1111, DWELL=4, ready=1: channel values 3,7,17,30.
    tbl[0]  = mk(1, 0, 0, 0,  0, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0,  0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0,  0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0,  0, 1, 0);
    tbl[4]  = mk(0, 0, 1, 0,  3, 1, 0);
    tbl[5]  = mk(0, 1, 0, 0,  3, 1, 1);
    tbl[6]  = mk(0, 1, 0, 0,  3, 1, 1);
    tbl[7]  = mk(0, 1, 0, 0,  3, 1, 1);
    tbl[8]  = mk(0, 1, 0, 0,  3, 1, 1);
    tbl[9]  = mk(0, 1, 1, 1,  7, 1, 1);
    tbl[10] = mk(0, 2, 0, 1,  7, 1, 2);
    tbl[11] = mk(0, 2, 0, 1,  7, 1, 2);
    tbl[12] = mk(0, 2, 0, 1,  7, 1, 2);
    tbl[13] = mk(0, 2, 0, 1,  7, 1, 2);
    tbl[14] = mk(0, 2, 1, 2, 17, 1, 2);
    tbl[15] = mk(0, 3, 0, 2, 17, 1, 3);
    tbl[16] = mk(0, 3, 0, 2, 17, 1, 3);
    tbl[17] = mk(0, 3, 0, 2, 17, 1, 3);
    tbl[18] = mk(0, 3, 0, 2, 17, 1, 3);
    tbl[19] = mk(0, 3, 1, 3, 30, 1, 3);
    tbl[20] = mk(0, 0, 0, 3, 30, 1, 4);

    chan_val[0] = 5'd3; chan_val[1] = 5'd7; chan_val[2] = 5'd17; chan_val[3] = 5'd30;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    check_model("reset");
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;

    // Round-robin over all four channels, one sample every DWELL+1 cycles.
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].start, 0, 4'hF, 1);
      cycle("table");
      vectors++;
      if (select !== tbl[i].exp_sel || out_valid !== tbl[i].exp_valid ||
          out_ch !== tbl[i].exp_ch || int'(out_data) != tbl[i].exp_data ||
          busy !== tbl[i].exp_busy || int'(scan_cnt) != tbl[i].exp_cnt) begin
        miscompares++;
        $display("FAIL table row %0d: got sel=%0d valid=%0d ch=%0d data=%0d busy=%0d cnt=%0d expected sel=%0d valid=%0d ch=%0d data=%0d busy=%0d cnt=%0d",
                 i, select, out_valid, out_ch, out_data, busy, scan_cnt,
                 tbl[i].exp_sel, tbl[i].exp_valid, tbl[i].exp_ch, tbl[i].exp_data,
                 tbl[i].exp_busy, tbl[i].exp_cnt);
      end
    end

    // Reset while in SETTLE, then restart from channel 0.
    apply_reset();
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_cnt", int'(scan_cnt), 0);
    drive(1, 0, 4'hF, 1);
    cycle("restart");
    chk("restart_sel", int'(select), 0);
    drive(0, 0, 4'hF, 1);

    // mask=1010: select alternates 1,3,1,3.
    apply_reset();
    drive(1, 0, 4'b1010, 1);
    for (int i = 0; i < 40; i++) begin
      if (out_valid && out_ready && got_ch.size() < 4) got_ch.push_back(out_ch);
      if (busy && (select == 2'd0 || select == 2'd2)) chk("mask1010_sel_disabled", int'(select), 1);
      cycle("mask1010");
      start = 1'b0;
    end
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd3; exp_seq[2] = 2'd1; exp_seq[3] = 2'd3;
    chk("mask1010_count", got_ch.size(), 4);
    for (int i = 0; i < got_ch.size() && i < 4; i++) chk("mask1010_ch", int'(got_ch[i]), int'(exp_seq[i]));

    // Backpressure: 10 cycles with ready low while holding a sample.
    apply_reset();
    chan_val[0] = 5'd21; chan_val[1] = 5'd9; chan_val[2] = 5'd14; chan_val[3] = 5'd2;
    drive(1, 0, 4'hF, 0);
    cycle("bp_start");
    start = 1'b0;
    wait_valid(20, "bp");
    snap_data = out_data; snap_ch = out_ch; snap_sel = select; snap_cnt = int'(scan_cnt);
    for (int i = 0; i < 10; i++) begin
      chan_val[0] = 5'($urandom);
      cycle("bp_hold");
    end
    chk("bp_data_stable", int'(out_data), int'(snap_data));
    chk("bp_ch_stable", int'(out_ch), int'(snap_ch));
    chk("bp_sel_stable", int'(select), int'(snap_sel));
    chk("bp_valid_stable", int'(out_valid), 1);
    chk("bp_cnt_stable", int'(scan_cnt), snap_cnt);
    out_ready = 1'b1;
    cycle("bp_release");
    out_ready = 1'b0;
    chk("bp_one_transfer", int'(scan_cnt), snap_cnt + 1);
    chk("bp_valid_drop", int'(out_valid), 0);

    // Stop during SETTLE on channel 2: sample still delivered, then idle.
    apply_reset();
    chan_val[2] = 5'd25;
    drive(1, 0, 4'b0100, 1);
    cycle("stop_start");
    drive(0, 1, 4'b0100, 1);
    cycle("stop_pulse");
    stop = 1'b0;
    repeat (10) cycle("stop_drain");
    chk("stop_busy", int'(busy), 0);
    chk("stop_ch", int'(out_ch), 2);
    chk("stop_data", int'(out_data), 25);
    chk("stop_cnt", int'(scan_cnt), 1);

    // start with an empty mask is ignored.
    apply_reset();
    drive(1, 0, 4'h0, 1);
    repeat (3) cycle("mask0_start");
    chk("mask0_busy", int'(busy), 0);

    // Mask cleared while holding: scan ends after the handshake.
    drive(1, 0, 4'hF, 0);
    cycle("maskdrop_start");
    start = 1'b0;
    wait_valid(20, "maskdrop");
    drive(0, 0, 4'h0, 1);
    cycle("maskdrop_hs");
    chk("maskdrop_busy", int'(busy), 0);
    chk("maskdrop_cnt", int'(scan_cnt), 1);

    // 256 transfers wrap the counter back to 0.
    apply_reset();
    drive(1, 0, 4'hF, 1);
    hs = 0;
    for (int i = 0; i < 2000 && hs < 256; i++) begin
      if (out_valid && out_ready) hs++;
      cycle("wrap");
      start = 1'b0;
    end
    chk("wrap_handshakes", hs, 256);
    chk("wrap_cnt", int'(scan_cnt), 0);

    // Randomized run against the model.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) ch_mask = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int c = 0; c < 4; c++) chan_val[c] = WIDTH'($urandom);
      if (i == 1500) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("rand_reset");
        @(negedge clk);
        rst_n = 1'b1;
      end
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
